// File: rtl/serial_cla_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default operand width.
package serial_cla_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_cla_ctrl_pgu_su.sv
// Single-bit propagate/generate/sum cell shared by the serial sequencer.
module pgu_su (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic p,
    output logic g,
    output logic s,
    output logic cout
);

    assign p    = a ^ b;
    assign g    = a & b;
    assign s    = p ^ cin;
    assign cout = g | (p & cin);

endmodule

// File: rtl/serial_cla_ctrl.sv
// Bit-serial adder sequencer: walks one pgu_su cell over WIDTH bits, LSB first, and
// assembles sum, carry-out and the group propagate/generate terms.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on the start edge
// ST_RUN  | one bit per clock through the cell, idx 0..WIDTH-1
// ST_DONE | one-cycle done pulse, then back to ST_IDLE
module serial_cla_ctrl
    import serial_cla_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             carry_q, carry_d;
    logic             p_acc_q, p_acc_d;
    logic             g_acc_q, g_acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             grp_p_q, grp_p_d;
    logic             grp_g_q, grp_g_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cell_p, cell_g, cell_s, cell_c;

    // Operand shift registers present the current bit pair at position 0.
    pgu_su u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .p    (cell_p),
        .g    (cell_g),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        work_d  = work_q;
        carry_d = carry_q;
        p_acc_d = p_acc_q;
        g_acc_d = g_acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        grp_p_d = grp_p_q;
        grp_g_d = grp_g_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    p_acc_d = 1'b1;
                    g_acc_d = 1'b0;
                    work_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d[idx_q] = cell_s;
                carry_d       = cell_c;
                p_acc_d       = p_acc_q & cell_p;
                g_acc_d       = cell_g | (cell_p & g_acc_q);
                a_sh_d        = a_sh_q >> 1;
                b_sh_d        = b_sh_q >> 1;
                if (idx_q == IDX_LAST) begin
                    // Results are published from the freshly updated values on the last bit.
                    sum_d   = work_d;
                    cout_d  = cell_c;
                    grp_p_d = p_acc_d;
                    grp_g_d = g_acc_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            p_acc_q <= 1'b0;
            g_acc_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            grp_p_q <= 1'b0;
            grp_g_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            p_acc_q <= p_acc_d;
            g_acc_q <= g_acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            grp_p_q <= grp_p_d;
            grp_g_q <= grp_g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign grp_p = grp_p_q;
    assign grp_g = grp_g_q;

endmodule

// File: tb/tb_serial_cla_ctrl.sv
// Scoreboard bench for serial_cla_ctrl at WIDTH=8; inputs driven and outputs sampled on the falling edge.
module tb_serial_cla_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         cin_in;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout, grp_p, grp_g;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         p;
        logic         g;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    serial_cla_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin_in (cin_in),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .grp_p  (grp_p),
        .grp_g  (grp_g)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        logic [W:0] u;
        exp_t       e;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        u      = {1'b0, a} + {1'b0, b};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.p    = &(a ^ b);
        e.g    = u[W];
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge of the first busy cycle.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
        a_in  = a;
        b_in  = b;
        cin_in = c;
        start = 1'b1;
        sb.push_back(model(a, b, c));
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Bounded wait for done; lat counts cycles since the capture edge.
    task automatic wait_done(output int lat, output int busy_n, output bit ok);
        lat = 1;
        busy_n = 0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy) busy_n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        cin_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sum, cout, grp_p, grp_g} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b p=%b g=%b, want all 0",
                     busy, done, sum, cout, grp_p, grp_g);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        bit ok;
        exp_t e;
        launch(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL basic_timeout: no done within bound");
        end else begin
            n_checks += 4;
            if (lat !== W + 1) begin
                n_errors++;
                $display("FAIL basic_latency: got %0d, want %0d", lat, W + 1);
            end
            if (bn !== W) begin
                n_errors++;
                $display("FAIL basic_busy_cycles: got %0d, want %0d", bn, W);
            end
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_busy_at_done: got %b, want 0", busy);
            end
            if ({sum, cout, grp_p, grp_g} !== e) begin
                n_errors++;
                $display("FAIL basic_result: got sum=%h cout=%b p=%b g=%b, want sum=%h cout=%b p=%b g=%b",
                         sum, cout, grp_p, grp_g, e.sum, e.cout, e.p, e.g);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_pulse: got done=%b after one cycle, want 0", done);
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] av [2];
        logic [W-1:0] bv [2];
        logic         cv [2];
        int lat, bn;
        bit ok;
        exp_t e;
        av[0] = 8'hFF; bv[0] = 8'h01; cv[0] = 1'b0;
        av[1] = 8'hFF; bv[1] = 8'h00; cv[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            launch(av[k], bv[k], cv[k], 1'b0);
            wait_done(lat, bn, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL carry_timeout[%0d]: no done within bound", k);
            end else begin
                n_checks += 2;
                if ({sum, cout, grp_p, grp_g} !== e) begin
                    n_errors++;
                    $display("FAIL carry_result[%0d]: got sum=%h cout=%b p=%b g=%b, want sum=%h cout=%b p=%b g=%b",
                             k, sum, cout, grp_p, grp_g, e.sum, e.cout, e.p, e.g);
                end
                if (cout !== (grp_g | (grp_p & cv[k]))) begin
                    n_errors++;
                    $display("FAIL carry_invariant[%0d]: got cout=%b, want %b", k, cout, grp_g | (grp_p & cv[k]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_hold();
        int lat, bn;
        bit ok;
        exp_t e;
        launch(8'h10, 8'h01, 1'b0, 1'b1);
        a_in = 8'hFF;
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL hold_timeout: no done within bound");
        end else begin
            n_checks += 2;
            if (lat !== W + 1) begin
                n_errors++;
                $display("FAIL hold_latency: got %0d, want %0d", lat, W + 1);
            end
            if (sum !== e.sum) begin
                n_errors++;
                $display("FAIL hold_sum: got %h, want %h", sum, e.sum);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_no_requeue: got busy=%b done=%b in idle, want 0 0", busy, done);
        end
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_idle_stays: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bn, stray;
        bit ok;
        exp_t e;
        launch(8'h3C, 8'h0F, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        n_checks++;
        if ({busy, done, sum, cout, grp_p, grp_g} !== '0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got busy=%b done=%b sum=%h cout=%b p=%b g=%b, want all 0",
                     busy, done, sum, cout, grp_p, grp_g);
        end
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++;
            $display("FAIL midrst_discard: got %0d cycles with done/busy, want 0", stray);
        end
        launch(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL midrst_timeout: no done within bound");
        end else if ({sum, cout, grp_p, grp_g} !== e) begin
            n_errors++;
            $display("FAIL midrst_result: got sum=%h cout=%b p=%b g=%b, want sum=%h cout=%b p=%b g=%b",
                     sum, cout, grp_p, grp_g, e.sum, e.cout, e.p, e.g);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bn, c1, c2, drift;
        bit ok;
        exp_t e;
        c1 = cyc;
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL b2b_first_timeout: no done within bound");
        end else if (sum !== e.sum || cout !== e.cout) begin
            n_errors++;
            $display("FAIL b2b_first: got sum=%h cout=%b, want sum=%h cout=%b", sum, cout, e.sum, e.cout);
        end
        @(negedge clk);
        c2 = cyc;
        n_checks++;
        if (c2 - c1 != W + 2) begin
            n_errors++;
            $display("FAIL b2b_spacing: got %0d cycles, want %0d", c2 - c1, W + 2);
        end
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        drift = 0;
        for (int i = 0; i < W - 1; i++) begin
            if (sum !== 8'h02) drift++;
            @(negedge clk);
        end
        n_checks++;
        if (drift != 0) begin
            n_errors++;
            $display("FAIL b2b_sum_hold: got %0d cycles with sum != 02 during run, want 0", drift);
        end
        wait_done(lat, bn, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL b2b_second_timeout: no done within bound");
        end else if ({sum, cout, grp_p, grp_g} !== e) begin
            n_errors++;
            $display("FAIL b2b_second: got sum=%h cout=%b p=%b g=%b, want sum=%h cout=%b p=%b g=%b",
                     sum, cout, grp_p, grp_g, e.sum, e.cout, e.p, e.g);
        end
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        cin_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_start_hold();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
